// File: rtl/seq_chunk_addsub_pkg.sv
// Shared ALU definitions for the chunked add/sub unit: FSM encoding, mode
// constants and the width/chunk compatibility check.
package seq_chunk_addsub_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  // Operands must split into a whole number of slices.
  function automatic bit chunk_fit(input int width, input int chunk);
    return (chunk > 0) && (width >= chunk) && ((width % chunk) == 0);
  endfunction

endpackage

// File: rtl/seq_chunk_addsub_chunk_adder.sv
// CHUNK-bit ripple adder slice built from full_adder cells; also exposes the
// carry into its top bit so the caller can form signed overflow.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module chunk_adder #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout,
  output logic             cmsb
);
  logic [CHUNK:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < CHUNK; i++) begin : g_fa
    full_adder u_fa (
      .a  (a[i]),
      .b  (b[i]),
      .ci (c[i]),
      .s  (s[i]),
      .co (c[i+1])
    );
  end

  assign cout = c[CHUNK];
  assign cmsb = c[CHUNK-1];
endmodule

// File: rtl/seq_chunk_addsub.sv
// Multi-cycle add/subtract: one CHUNK-bit slice per clock, LSB first, with a
// start/done handshake and Carry/Overflow/Zero flags registered at the end.
module seq_chunk_addsub
  import seq_chunk_addsub_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             C0,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Sum,
  output logic             Carry,
  output logic             Overflow,
  output logic             Zero
);
  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  if (!chunk_fit(WIDTH, CHUNK)) begin : g_bad_cfg
    $error("seq_chunk_addsub: WIDTH must be a positive multiple of CHUNK");
  end

  logic [1:0]       state, state_nx;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_q, b_q, sum_nx;
  logic             cy_q;
  logic             accept, last;
  int               idx;
  logic [CHUNK-1:0] sl_sum;
  logic             sl_cout, sl_cmsb;

  assign accept = start && ((state == ST_IDLE) || (state == ST_DONE));
  assign last   = (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (start) state_nx = ST_RUN;
      ST_RUN:  if (last)  state_nx = ST_DONE;
      ST_DONE: state_nx = start ? ST_RUN : ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state == ST_RUN);
    done = (state == ST_DONE);
  end

  always_comb begin
    idx    = int'(cnt) * CHUNK;
    sum_nx = Sum;
    sum_nx[idx +: CHUNK] = sl_sum;
  end

  chunk_adder #(.CHUNK(CHUNK)) u_slice (
    .a    (a_q[idx +: CHUNK]),
    .b    (b_q[idx +: CHUNK]),
    .cin  (cy_q),
    .s    (sl_sum),
    .cout (sl_cout),
    .cmsb (sl_cmsb)
  );

  // Subtraction is folded into the operands at accept time: A + ~B + ~C0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      cy_q     <= 1'b0;
      cnt      <= '0;
      Sum      <= '0;
      Carry    <= 1'b0;
      Overflow <= 1'b0;
      Zero     <= 1'b0;
    end else if (accept) begin
      a_q  <= A;
      b_q  <= (sub == MODE_SUB) ? ~B : B;
      cy_q <= (sub == MODE_SUB) ? ~C0 : C0;
      cnt  <= '0;
    end else if (state == ST_RUN) begin
      Sum  <= sum_nx;
      cy_q <= sl_cout;
      cnt  <= cnt + 1'b1;
      if (last) begin
        Carry    <= sl_cout;
        Overflow <= sl_cmsb ^ sl_cout;
        Zero     <= (sum_nx == '0);
      end
    end
  end

endmodule
